// File: rtl/g10_block_lock_ctrl_pkg.sv
// Shared types and sync-header helpers for the 10GBASE-R block-lock controller.
package pcs_lock_pkg;

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST      = 2'd1,
    SWAIT     = 2'd2
  } lock_state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/g10_block_lock_ctrl_if.sv
// Gearbox/management-side signal bundle of the block-lock controller.
interface g10_block_lock_ctrl_if;
  logic        lock_en;
  logic        sh_valid;
  logic [1:0]  sh;
  logic        clr_cnt;
  logic        slip;
  logic        block_lock;
  logic        hi_ber;
  logic [15:0] slip_cnt;
  logic [15:0] ber_err_cnt;

  modport master (
    output lock_en, sh_valid, sh, clr_cnt,
    input  slip, block_lock, hi_ber, slip_cnt, ber_err_cnt
  );

  modport slave (
    input  lock_en, sh_valid, sh, clr_cnt,
    output slip, block_lock, hi_ber, slip_cnt, ber_err_cnt
  );
endinterface

// File: rtl/g10_block_lock_ctrl_ber_monitor.sv
// Hi-BER monitor: counts invalid headers per fixed window while block_lock is held.
module g10_ber_monitor
  import pcs_lock_pkg::*;
#(
  parameter int BER_WINDOW = 19531,
  parameter int BER_MAX    = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic block_lock_i,
  input  logic inv_strobe_i,
  output logic hi_ber_o
);

  localparam int TMR_W = $clog2(BER_WINDOW);
  localparam int CNT_W = $clog2(BER_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BER_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BER_MAX);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hi_q, hi_d;

  // Down-counting timer: terminal count 0 marks the window wrap cycle.
  always_comb begin
    tmr_d = tmr_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    if (!block_lock_i) begin
      tmr_d = TMR_LOAD;
      cnt_d = '0;
      hi_d  = 1'b0;
    end else if (tmr_q == '0) begin
      tmr_d = TMR_LOAD;
      cnt_d = CNT_W'(inv_strobe_i);
      if (cnt_q < CNT_SAT) hi_d = 1'b0;
    end else begin
      tmr_d = tmr_q - TMR_W'(1);
      if (inv_strobe_i && (cnt_q != CNT_SAT)) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_SAT) hi_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmr_q <= TMR_LOAD;
      cnt_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  assign hi_ber_o = hi_q;

endmodule

// File: rtl/g10_block_lock_ctrl.sv
// 10GBASE-R receive block-lock FSM with slip sequencing, status counters and hi-BER monitor.
module g10_block_lock_ctrl
  import pcs_lock_pkg::*;
#(
  parameter int          SH_CNT_MAX   = 64,
  parameter int          SH_INV_MAX   = 16,
  parameter int          SLIP_WAIT    = 32,
  parameter int          BER_WINDOW   = 19531,
  parameter int          BER_MAX      = 16,
  parameter logic [15:0] STAT_RST_VAL = 16'h0000
) (
  input  logic                  clk_156,
  input  logic                  rst_156,
  g10_block_lock_ctrl_if.slave  pcs_if
);

  // state     | meaning
  // RESET_CNT | clear window counters, wait for lock_en
  // TEST      | count headers per window, decide lock or slip
  // SWAIT     | ignore headers while the gearbox realigns
  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(SH_CNT_MAX);
  localparam logic [CNT_W-1:0]  INV_END   = CNT_W'(SH_INV_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT - 1);

  lock_state_e       state_q;
  logic [CNT_W-1:0]  sh_cnt_q, inv_cnt_q;
  logic [WAIT_W-1:0] wait_q;
  logic              slip_q, lock_q;
  logic [15:0]       slip_cnt_q, err_cnt_q;

  logic              hdr_bad, hdr_take, slip_evt, err_evt, win_end;
  logic [CNT_W-1:0]  cnt_nxt, inv_nxt;

  assign hdr_bad  = !sh_is_valid(pcs_if.sh);
  assign hdr_take = pcs_if.lock_en && pcs_if.sh_valid && (state_q == TEST);
  assign cnt_nxt  = sh_cnt_q + CNT_W'(1);
  assign inv_nxt  = inv_cnt_q + CNT_W'(hdr_bad);
  assign win_end  = (cnt_nxt == CNT_END);
  // Slip check wins over the window-end decision.
  assign slip_evt = hdr_take && hdr_bad && (!lock_q || (inv_nxt == INV_END));
  assign err_evt  = hdr_take && hdr_bad && lock_q;

  always_ff @(posedge clk_156 or posedge rst_156) begin
    if (rst_156) begin
      state_q   <= RESET_CNT;
      sh_cnt_q  <= '0;
      inv_cnt_q <= '0;
      wait_q    <= '0;
      slip_q    <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      slip_q <= 1'b0;
      if (!pcs_if.lock_en) begin
        state_q   <= RESET_CNT;
        lock_q    <= 1'b0;
        sh_cnt_q  <= '0;
        inv_cnt_q <= '0;
        wait_q    <= '0;
      end else begin
        case (state_q)
          RESET_CNT: begin
            sh_cnt_q  <= '0;
            inv_cnt_q <= '0;
            state_q   <= TEST;
          end
          TEST: begin
            if (pcs_if.sh_valid) begin
              if (slip_evt) begin
                slip_q    <= 1'b1;
                lock_q    <= 1'b0;
                sh_cnt_q  <= '0;
                inv_cnt_q <= '0;
                wait_q    <= WAIT_LOAD;
                state_q   <= SWAIT;
              end else if (win_end) begin
                if (inv_nxt == '0) lock_q <= 1'b1;
                sh_cnt_q  <= '0;
                inv_cnt_q <= '0;
              end else begin
                sh_cnt_q  <= cnt_nxt;
                inv_cnt_q <= inv_nxt;
              end
            end
          end
          SWAIT: begin
            if (pcs_if.sh_valid) begin
              if (wait_q == '0) state_q <= TEST;
              else              wait_q  <= wait_q - WAIT_W'(1);
            end
          end
          default: state_q <= RESET_CNT;
        endcase
      end
    end
  end

  // A clear coinciding with an event leaves 1 so the event is not lost.
  always_ff @(posedge clk_156 or posedge rst_156) begin
    if (rst_156) begin
      slip_cnt_q <= STAT_RST_VAL;
      err_cnt_q  <= STAT_RST_VAL;
    end else begin
      if (pcs_if.clr_cnt)                          slip_cnt_q <= {15'd0, slip_evt};
      else if (slip_evt && (slip_cnt_q != 16'hFFFF)) slip_cnt_q <= slip_cnt_q + 16'd1;
      if (pcs_if.clr_cnt)                          err_cnt_q  <= {15'd0, err_evt};
      else if (err_evt && (err_cnt_q != 16'hFFFF))   err_cnt_q  <= err_cnt_q + 16'd1;
    end
  end

  g10_ber_monitor #(
    .BER_WINDOW (BER_WINDOW),
    .BER_MAX    (BER_MAX)
  ) u_ber (
    .clk_i        (clk_156),
    .rst_i        (rst_156),
    .block_lock_i (lock_q),
    .inv_strobe_i (err_evt),
    .hi_ber_o     (pcs_if.hi_ber)
  );

  assign pcs_if.slip        = slip_q;
  assign pcs_if.block_lock  = lock_q;
  assign pcs_if.slip_cnt    = slip_cnt_q;
  assign pcs_if.ber_err_cnt = err_cnt_q;

endmodule
